// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: opcodes, control encodings and the
// main controller state type. MAIN_FSM_ILLEGAL_TRAP_EN adds the StTrap state.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    StJal      = 4'd10,
    StTrap     = 4'd11
`else
    StJal      = 4'd10
`endif
  } main_state_t;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main controller (master) and the datapath (slave).
// MAIN_FSM_ILLEGAL_TRAP_EN adds the IllegalInstr flag.
interface main_fsm_if;
  logic [6:0] Opcode;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic       IllegalInstr;
`endif

  modport master (
    input  Opcode, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    output IllegalInstr,
`endif
    output ImmSrc, RegWrite
  );

  modport slave (
    output Opcode, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    input  IllegalInstr,
`endif
    input  ImmSrc, RegWrite
  );
endinterface

// File: rtl/instr_decoder.sv
// Opcode -> immediate format select; state independent.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [1:0] imm_src_o
);

  // Unsupported opcodes (and R-type, which has no immediate) fall to I format.
  always_comb begin
    imm_src_o = IMM_I;
    case (opcode_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: Moore FSM sequencing Fetch/Decode/Execute/
// Memory/Writeback. MAIN_FSM_ILLEGAL_TRAP_EN sends illegal opcodes to a sticky
// StTrap state flagged on IllegalInstr; otherwise they retire as a NOP.
module main_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input logic       clk,
  input logic       reset,
  main_fsm_if.master bus
);

  logic [STATE_W-1:0] state_q, state_d;

  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       illegal;

  // State register with synchronous reset to StFetch.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs; reset shows Fetch selects with writes blocked.
  always_comb begin
    state_d    = StFetch;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    if (reset) begin
      alu_src_b  = SRCB_FOUR;
      result_src = RES_ALURESULT;
    end else begin
      case (state_q)
        StFetch: begin
          state_d    = StDecode;
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
        end
        StDecode: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (bus.Opcode)
            OP_LW, OP_SW: state_d = StMemAdr;
            OP_R:         state_d = StExecuteR;
            OP_I:         state_d = StExecuteI;
            OP_BEQ:       state_d = StBeq;
            OP_JAL:       state_d = StJal;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            default:      state_d = StTrap;
`else
            default:      state_d = StFetch;
`endif
          endcase
        end
        StMemAdr: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          if (bus.Opcode == OP_LW)      state_d = StMemRead;
          else if (bus.Opcode == OP_SW) state_d = StMemWrite;
          else                          state_d = StFetch;
        end
        StMemRead: begin
          state_d = StMemWb;
          adr_src = 1'b1;
        end
        StMemWb: begin
          result_src = RES_READDATA;
          reg_write  = 1'b1;
        end
        StMemWrite: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        StExecuteR: begin
          state_d   = StAluWb;
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
        end
        StExecuteI: begin
          state_d   = StAluWb;
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
        end
        StAluWb: begin
          reg_write = 1'b1;
        end
        StBeq: begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_SUB;
          branch    = 1'b1;
        end
        StJal: begin
          state_d   = StAluWb;
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_update = 1'b1;
        end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        StTrap: begin
          state_d = StTrap;
          illegal = 1'b1;
        end
`endif
        // Unused encodings recover to Fetch with everything deasserted.
        default: state_d = StFetch;
      endcase
    end
  end

  assign bus.PCWrite   = pc_update | (branch & bus.Zero);
  assign bus.AdrSrc    = adr_src;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign bus.IllegalInstr = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

  instr_decoder u_instr_decoder (
    .opcode_i  (bus.Opcode),
    .imm_src_o (bus.ImmSrc)
  );

endmodule
